// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - sideband symbol constants, CRC parameters and checker state type
package sb_pkg;

   localparam logic [7:0] DLE     = 8'hFE;
   localparam logic [7:0] STX_CMD = 8'h05;
   localparam logic [7:0] STX_RSP = 8'h04;
   localparam logic [7:0] ETX     = 8'h40;
   localparam logic [7:0] LSE     = 8'h80;
   localparam logic [7:0] CLSE    = 8'h7F;

   localparam logic [15:0] CRC_POLY = 16'h8005;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DLE1     = 2'd1,
      ST_DATA     = 2'd2,
      ST_DATA_DLE = 2'd3
   } sb_state_e;

endpackage

// File: rtl/sb_crc16_byte.sv
// rtl/sb_crc16_byte.sv - combinational CRC-16 byte update, MSB-first register, data LSB first
module sb_crc16_byte
   import sb_pkg::*;
#(
   parameter logic [15:0] POLY = CRC_POLY
) (
   input  logic [15:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [15:0] crc_o
);

   logic [15:0] c;

   always_comb begin
      c = crc_i;
      // data_i[0] is the first bit on the line, so it is consumed first
      for (int i = 0; i < 8; i++) begin
         if (c[15] ^ data_i[i]) begin
            c = {c[14:0], 1'b0} ^ POLY;
         end else begin
            c = {c[14:0], 1'b0};
         end
      end
      crc_o = c;
   end

endmodule

// File: rtl/sb_rx_crc_checker.sv
// rtl/sb_rx_crc_checker.sv - sideband RX deframer: DLE unstuffing, CRC-16 check, framing faults
module sb_rx_crc_checker
   import sb_pkg::*;
#(
   parameter int          MAX_BYTES = 70,
   parameter logic [15:0] POLY      = CRC_POLY,
   parameter logic [15:0] INIT      = CRC_INIT
) (
   input  logic        sb_clk,
   input  logic        rst,
   input  logic [9:0]  sbrx,
   input  logic        sym_valid,
   input  logic        crc_det_en,
   output logic        error,
   output logic        crc_ok,
   output logic [15:0] crc_value
);

   localparam int CW = $clog2(MAX_BYTES + 2);

   sb_state_e     state_q, state_d;
   logic [15:0]   crc_q, crc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    hold0_q, hold0_d;
   logic [7:0]    hold1_q, hold1_d;
   logic [1:0]    hcnt_q, hcnt_d;
   logic          error_q, error_d;
   logic          ok_q, ok_d;

   logic [7:0]    sym_byte;
   logic          sym_good;
   logic          is_stx;
   logic          do_push;
   logic          do_seed;
   logic [15:0]   crc_seed;
   logic [15:0]   crc_fold;

   assign sym_byte = sbrx[8:1];
   assign sym_good = ~sbrx[0] & sbrx[9];
   assign is_stx   = (sym_byte == STX_CMD) || (sym_byte == STX_RSP);

   sb_crc16_byte #(.POLY(POLY)) u_crc_seed (
      .crc_i  (INIT),
      .data_i (sym_byte),
      .crc_o  (crc_seed)
   );

   // The byte leaving hold1 is known to be payload, not one of the trailing CRC bytes
   sb_crc16_byte #(.POLY(POLY)) u_crc_fold (
      .crc_i  (crc_q),
      .data_i (hold1_q),
      .crc_o  (crc_fold)
   );

   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      cnt_d   = cnt_q;
      hold0_d = hold0_q;
      hold1_d = hold1_q;
      hcnt_d  = hcnt_q;
      error_d = 1'b0;
      ok_d    = 1'b0;
      do_push = 1'b0;
      do_seed = 1'b0;

      if (sym_valid) begin
         if (!sym_good) begin
            if (state_q != ST_IDLE) begin
               error_d = 1'b1;
               state_d = ST_IDLE;
            end
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (sym_byte == DLE) state_d = ST_DLE1;
               end
               ST_DLE1: begin
                  if (is_stx && crc_det_en) begin
                     do_seed = 1'b1;
                  end else if (sym_byte != DLE) begin
                     state_d = ST_IDLE;
                  end
               end
               ST_DATA: begin
                  if (sym_byte == DLE) state_d = ST_DATA_DLE;
                  else                 do_push = 1'b1;
               end
               ST_DATA_DLE: begin
                  if (sym_byte == DLE) begin
                     do_push = 1'b1;
                     state_d = ST_DATA;
                  end else if (sym_byte == ETX) begin
                     if ((hcnt_q == 2'd2) && (crc_q == {hold0_q, hold1_q})) ok_d = 1'b1;
                     else                                                   error_d = 1'b1;
                     state_d = ST_IDLE;
                  end else if (is_stx) begin
                     error_d = 1'b1;
                     do_seed = 1'b1;
                  end else begin
                     error_d = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end

      if (do_seed) begin
         crc_d   = crc_seed;
         cnt_d   = '0;
         hold0_d = 8'h00;
         hold1_d = 8'h00;
         hcnt_d  = 2'd0;
         state_d = ST_DATA;
      end

      if (do_push) begin
         hold0_d = sym_byte;
         hold1_d = hold0_q;
         if (hcnt_q == 2'd2) crc_d  = crc_fold;
         else                hcnt_d = hcnt_q + 2'd1;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(MAX_BYTES)) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         crc_q   <= INIT;
         cnt_q   <= '0;
         hold0_q <= 8'h00;
         hold1_q <= 8'h00;
         hcnt_q  <= 2'd0;
         error_q <= 1'b0;
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         cnt_q   <= cnt_d;
         hold0_q <= hold0_d;
         hold1_q <= hold1_d;
         hcnt_q  <= hcnt_d;
         error_q <= error_d;
         ok_q    <= ok_d;
      end
   end

   assign error     = error_q;
   assign crc_ok    = ok_q;
   assign crc_value = crc_q;

endmodule

// File: tb/tb_sb_rx_crc_checker.sv
// tb/tb_sb_rx_crc_checker.sv - scoreboard bench for sb_rx_crc_checker
module tb_sb_rx_crc_checker;

   localparam int EV_NONE = 0;
   localparam int EV_OK   = 1;
   localparam int EV_ERR  = 2;

   typedef struct {
      logic        is_ok;
      int          cyc;
      logic [15:0] crc;
   } exp_t;

   logic        sb_clk = 1'b0;
   logic        rst;
   logic [9:0]  sbrx;
   logic        sym_valid;
   logic        crc_det_en;
   logic        error;
   logic        crc_ok;
   logic [15:0] crc_value;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [7:0]  pl[$];

   sb_rx_crc_checker dut (
      .sb_clk     (sb_clk),
      .rst        (rst),
      .sbrx       (sbrx),
      .sym_valid  (sym_valid),
      .crc_det_en (crc_det_en),
      .error      (error),
      .crc_ok     (crc_ok),
      .crc_value  (crc_value)
   );

   always #5 sb_clk = ~sb_clk;
   always @(posedge sb_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, got, want);
      end
   endtask

   // Table-style CRC: reversed byte xored into the top, then eight plain shifts
   function automatic logic [15:0] model_upd(input logic [15:0] c, input logic [7:0] b);
      logic [7:0]  r;
      logic [15:0] x;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      x = c ^ {r, 8'h00};
      for (int i = 0; i < 8; i++) x = x[15] ? ((x << 1) ^ 16'h8005) : (x << 1);
      return x;
   endfunction

   function automatic logic [15:0] model_frame(input logic [7:0] stx);
      logic [15:0] c;
      c = model_upd(16'hFFFF, stx);
      foreach (pl[i]) c = model_upd(c, pl[i]);
      return c;
   endfunction

   task automatic send_sym(input logic [7:0] b, input logic start_b, input logic stop_b,
                           input int ev, input logic [15:0] ecrc);
      exp_t e;
      @(negedge sb_clk);
      sbrx      = {stop_b, b, start_b};
      sym_valid = 1'b1;
      if (ev != EV_NONE) begin
         e.is_ok = (ev == EV_OK);
         e.cyc   = cyc + 1;
         e.crc   = ecrc;
         exp_q.push_back(e);
      end
      @(negedge sb_clk);
      sym_valid = 1'b0;
   endtask

   task automatic put_sym(input logic [7:0] b);
      send_sym(b, 1'b0, 1'b1, EV_NONE, 16'h0);
   endtask

   task automatic put_data(input logic [7:0] b);
      if (b == 8'hFE) put_sym(8'hFE);
      put_sym(b);
   endtask

   task automatic frame(input logic [7:0] flip, input int ev);
      logic [15:0] c;
      c = model_frame(8'h05);
      put_sym(8'hFE);
      put_sym(8'h05);
      foreach (pl[i]) put_data(pl[i]);
      put_data(c[7:0] ^ flip);
      put_data(c[15:8]);
      put_sym(8'hFE);
      send_sym(8'h40, 1'b0, 1'b1, ev, c);
   endtask

   always @(negedge sb_clk) begin
      if (rst && (error || crc_ok)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {30'd0, error, crc_ok}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("exclusive", {31'd0, error & crc_ok}, 32'd0);
            chk("pulse_kind_ok", {31'd0, crc_ok}, {31'd0, mon_e.is_ok});
            chk("latency", mon_e.cyc, cyc);
            if (mon_e.is_ok) chk("crc_value", {16'd0, crc_value}, {16'd0, mon_e.crc});
         end
      end
   end

   initial begin
      logic [15:0] c;
      rst        = 1'b0;
      sbrx       = 10'h200;
      sym_valid  = 1'b0;
      crc_det_en = 1'b1;
      repeat (3) @(negedge sb_clk);
      chk("rst_error", {31'd0, error}, 32'd0);
      chk("rst_crc_ok", {31'd0, crc_ok}, 32'd0);
      chk("rst_crc_value", {16'd0, crc_value}, 32'h0000FFFF);
      rst = 1'b1;

      // good read command, then corrupted CRC low byte
      pl = '{8'h0C, 8'h01};
      frame(8'h00, EV_OK);
      frame(8'h01, EV_ERR);

      // stuffed FE payload byte
      pl = '{8'h0C, 8'hFE};
      frame(8'h00, EV_OK);

      // stop bit low on third payload symbol, then a clean frame
      put_sym(8'hFE); put_sym(8'h05); put_sym(8'h0C); put_sym(8'h01);
      send_sym(8'hAA, 1'b0, 1'b0, EV_ERR, 16'h0);
      pl = '{8'h0C, 8'h01};
      frame(8'h00, EV_OK);

      // link-type traffic and disabled detection stay silent
      put_sym(8'hFE); put_sym(8'h80); put_sym(8'hFE); put_sym(8'h40);
      put_sym(8'hFE); put_sym(8'h7F); put_sym(8'hFE); put_sym(8'h40);
      crc_det_en = 1'b0;
      put_sym(8'hFE); put_sym(8'h05); put_sym(8'h0C); put_sym(8'hFE); put_sym(8'h40);
      crc_det_en = 1'b1;

      // bad start bit in IDLE is ignored, so the rest is not a frame
      send_sym(8'hFE, 1'b1, 1'b1, EV_NONE, 16'h0);
      c = model_frame(8'h05);
      put_sym(8'h05); put_data(8'h0C); put_data(8'h01);
      put_data(c[7:0]); put_data(c[15:8]); put_sym(8'hFE); put_sym(8'h40);

      // illegal DLE sequence
      put_sym(8'hFE); put_sym(8'h05); put_sym(8'h0C); put_sym(8'hFE);
      send_sym(8'h33, 1'b0, 1'b1, EV_ERR, 16'h0);

      // restart inside a frame reseeds from the new STX
      put_sym(8'hFE); put_sym(8'h05); put_sym(8'h0C); put_sym(8'hFE);
      send_sym(8'h05, 1'b0, 1'b1, EV_ERR, 16'h0);
      pl = '{8'h01};
      c = model_frame(8'h05);
      put_data(8'h01); put_data(c[7:0]); put_data(c[15:8]); put_sym(8'hFE);
      send_sym(8'h40, 1'b0, 1'b1, EV_OK, c);

      // framing fault on the ETX symbol wins over the decode
      pl = '{8'h0C, 8'h01};
      c = model_frame(8'h05);
      put_sym(8'hFE); put_sym(8'h05); put_data(8'h0C); put_data(8'h01);
      put_data(c[7:0]); put_data(c[15:8]); put_sym(8'hFE);
      send_sym(8'h40, 1'b0, 1'b0, EV_ERR, 16'h0);

      // exactly 70 unstuffed bytes is still legal
      pl = {};
      for (int i = 1; i <= 68; i++) pl.push_back(8'(i + 100));
      frame(8'h00, EV_OK);

      // 71 bytes without ETX trips oversize on the 71st
      put_sym(8'hFE); put_sym(8'h05);
      for (int i = 1; i <= 70; i++) put_sym(8'(i));
      send_sym(8'd71, 1'b0, 1'b1, EV_ERR, 16'h0);
      put_sym(8'hFE); put_sym(8'h40);

      // asynchronous reset between CRC bytes and ETX
      pl = '{8'h0C, 8'h01};
      c = model_frame(8'h05);
      put_sym(8'hFE); put_sym(8'h05); put_data(8'h0C); put_data(8'h01);
      put_data(c[7:0]); put_data(c[15:8]);
      @(negedge sb_clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_crc_value", {16'd0, crc_value}, 32'h0000FFFF);
      chk("midrst_error", {31'd0, error}, 32'd0);
      chk("midrst_crc_ok", {31'd0, crc_ok}, 32'd0);
      @(negedge sb_clk);
      rst = 1'b1;
      put_sym(8'hFE); put_sym(8'h40);
      frame(8'h00, EV_OK);

      repeat (4) @(negedge sb_clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sb_rx_crc_checker.md
Name: sb_rx_crc_checker

Overview:
- Sideband receive-path CRC checker that sits beside the transactions FSM and supplies its `error` input.
- Takes received 10-bit SB symbols, tracks DLE/STX…DLE/ETX framing and removes DLE stuffing.
- Computes CRC-16 over STX plus unstuffed payload and compares it against the two received CRC bytes.
- Also flags line-level framing faults: bad start/stop bit, illegal DLE sequence, oversize frame.

Parameters:
- MAX_BYTES, 70, max unstuffed bytes after STX (payload + 2 CRC) before oversize error
- CRC_POLY, 16'h8005, CRC-16 generator polynomial x^16+x^15+x^2+1
- CRC_INIT, 16'hFFFF, CRC seed loaded on STX

Ports:
- sb_clk  in  1  sideband clock
- rst  in  1  asynchronous, active-low reset
- sbrx  in  10  received symbol: [0] start bit, [8:1] data byte, [9] stop bit
- sym_valid  in  1  one-cycle strobe; sbrx is valid on this cycle
- crc_det_en  in  1  CRC detection enable from transactions FSM; sampled only on the STX symbol
- error  out  1  registered one-cycle pulse on CRC mismatch or framing fault
- crc_ok  out  1  registered one-cycle pulse on good frame at DLE/ETX
- crc_value  out  16  running CRC register (debug/visibility)

Behaviour:
- Reset (rst low, async):
  - state=IDLE; error=0; crc_ok=0; crc_value=CRC_INIT.
  - Byte counter=0; holding bytes hold0/hold1=0; hold count=0.
- General rules:
  - All state changes occur only on sym_valid=1 cycles; other cycles hold state.
  - Symbol check on every sym_valid: sbrx[0] must be 0 and sbrx[9] must be 1.
  - A symbol failing this check in any non-IDLE state: error pulse, go to IDLE. In IDLE it is ignored.
- FSM states: IDLE, DLE1, DATA, DATA_DLE.
  - IDLE: byte 8'hFE -> DLE1; anything else stays IDLE.
  - DLE1, byte 8'h05 or 8'h04 with crc_det_en=1: crc=update(CRC_INIT, byte), clear counter and holds -> DATA.
  - DLE1, byte 8'hFE: stay DLE1.
  - DLE1, any other byte, or STX with crc_det_en=0: -> IDLE, no error (covers LSE/CLSE link-type traffic).
  - DATA, byte != 8'hFE: push byte into the 2-deep hold pipeline.
    - The byte displaced from hold1 is folded into the CRC.
    - Counter += 1.
  - DATA, byte == 8'hFE: -> DATA_DLE.
  - DATA_DLE, 8'hFE: stuffed data; push 8'hFE exactly as in DATA, counter += 1 -> DATA.
  - DATA_DLE, 8'h40 (ETX): frame end, compare.
    - crc_ok=1 if hold count == 2 and crc == {hold0, hold1}; otherwise error=1.
    - Byte order: hold1 is the earlier-received byte (CRC low byte), hold0 the later (CRC high byte).
    - Then -> IDLE.
  - DATA_DLE, 8'h05/8'h04: restart framing; error pulse for the aborted frame, reseed CRC with the new STX -> DATA.
  - DATA_DLE, any other byte: error pulse -> IDLE.
  - Oversize: counter reaching MAX_BYTES+1 in DATA: error pulse -> IDLE.
- CRC arithmetic:
  - Bitwise MSB-first shift of the CRC register.
  - Data bits fed LSB first (sbrx[1] first, matching line order).
  - No output reflection, no final XOR.
  - The CRC covers the STX byte and all unstuffed payload bytes; it excludes DLE prefixes, the CRC bytes and ETX.
- Latency: error/crc_ok assert on the cycle after the sym_valid cycle carrying the deciding symbol, and last exactly one cycle.
- Simultaneous events:
  - Framing-bit fault takes priority over any DLE/ETX decode.
  - error and crc_ok are never high together.
- Reset mid-frame: everything returns to reset values immediately; no pulse is generated.

Decomposition:
- Package sb_pkg holds:
  - Symbol constants: DLE 8'hFE, STX_CMD 8'h05, STX_RSP 8'h04, ETX 8'h40, LSE 8'h80, CLSE 8'h7F.
  - CRC_POLY and CRC_INIT.
  - The state enum typedef (logic [1:0]).
- Sub-module sb_crc16_byte: combinational next_crc = f(crc_in[15:0], byte[7:0]) per the CRC rules above. It is reused later by the TX CRC generator.

Test Plan:
- Good read command FE,05,addr 8'h0C,len 8'h01,CRC lo,CRC hi,FE,40 with CRC from the bench model -> crc_ok pulse once, error=0, crc_value == model value.
- Same frame with bit 0 of the CRC low byte flipped -> error pulse 1 cycle after the ETX strobe, crc_ok=0.
- Payload byte 8'hFE sent stuffed (FE,FE) -> the CRC includes a single 8'hFE; crc_ok=1.
- Stop bit 0 on the third payload symbol -> error pulse, state IDLE; the following valid frame passes with crc_ok.
- DLE1 followed by LSE 8'h80, then 71 payload bytes with no ETX inside a frame -> LSE: no error, stays IDLE. The 71-byte frame: error at byte 71.
- rst pulled low between a payload byte and ETX -> no pulse; crc_value=16'hFFFF; state IDLE.
